qpu_itcm_arb: RTL and testbench
===============================

# qpu_itcm_arb

Single-port ITCM access scheduler for the QPU. It shares one ITCM SRAM between the IFU fetch port and a host program-load port. IFU fetch runs by default. When the host requests exclusive access, the block sequences an IFU halt handshake, drains outstanding fetches, grants the host, and on host release resumes the IFU. It sits between `QPU_ifu_top` and the ITCM RAM macro and drives `itcm_active` for clock gating.

## Interface
- `AW`, 12: ITCM word-address width.
- `DW`, 32: ITCM data width (= `QPU_INSTR_SIZE`); `DW` is a multiple of 8.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ifu_cmd_valid` / `ifu_cmd_ready`  in/out  1/1  IFU read command handshake.
- `ifu_cmd_addr`  in  AW  IFU word address.
- `ifu_rsp_valid` / `ifu_rsp_ready`  out/in  1/1  IFU response handshake.
- `ifu_rsp_rdata`  out  DW  fetched word.
- `ifu_halt_req`  out  1  registered halt request to the IFU.
- `ifu_halt_ack`  in  1  IFU halted (level).
- `host_lock_req`  in  1  host requests exclusive ITCM ownership (level).
- `host_lock_gnt`  out  1  host owns ITCM.
- `host_cmd_valid` / `host_cmd_ready`  in/out  1/1  host command handshake.
- `host_cmd_read`  in  1  1 = read, 0 = write.
- `host_cmd_addr`  in  AW  host word address.
- `host_cmd_wdata`  in  DW  write data.
- `host_cmd_wmask`  in  DW/8  byte-write enables.
- `host_rsp_valid` / `host_rsp_ready`  out/in  1/1  host response handshake.
- `host_rsp_rdata`  out  DW  read data; 0 for write responses.
- `ram_cs`, `ram_we`  out  1  RAM chip select and write enable.
- `ram_addr`  out  AW  RAM address.
- `ram_wem`  out  DW/8  RAM byte mask.
- `ram_din`  out  DW  RAM write data.
- `ram_dout`  in  DW  RAM read data. Valid the cycle after `ram_cs`; held until the next `ram_cs`.
- `itcm_active`  out  1  any command or response in flight, or state ≠ IFU.

## Operation
- FSM states: IFU (reset state), DRAIN, HOST, RELEASE.
- **IFU**
  - `ifu_cmd_ready = 1` when no IFU response is outstanding, or the outstanding response handshakes this cycle.
  - `host_cmd_ready = 0`.
  - `host_lock_req = 1` → DRAIN.
- **DRAIN**
  - `ifu_halt_req = 1`; `ifu_cmd_ready = 0`.
  - → HOST when IFU outstanding = 0 and `ifu_halt_ack = 1`.
  - → RELEASE if `host_lock_req` falls first.
- **HOST**
  - `host_lock_gnt = 1`; `ifu_halt_req = 1`.
  - `host_cmd_ready` follows the same 1-outstanding rule as the IFU port.
  - → RELEASE when `host_lock_req = 0` and host outstanding = 0.
  - The command accepted in the cycle `host_lock_req` falls is still served.
- **RELEASE**
  - `ifu_halt_req = 0`; both `cmd_ready = 0`.
  - → IFU when `ifu_halt_ack = 0`.
  - A re-asserted `host_lock_req` is ignored until at least one cycle in IFU. This prevents host starvation of fetch.
- **Accepted command** (valid & ready):
  - `ram_cs = 1` combinationally; `ram_we = ~read`; address, mask and data pass through.
  - The owning port's outstanding flag is set.
  - `ram_wem` = `host_cmd_wmask` for host writes; all-ones ignored for reads.
- **Response path**
  - Response valid is registered, set the cycle after accept.
  - rdata = `ram_dout` (0 for writes).
  - Valid holds until the ready handshake clears the outstanding flag.
- At most one outstanding transaction per port. Only the owning port can have one, so the RAM never sees two owners.
- Host commands while `host_lock_gnt = 0` are not accepted (`host_cmd_ready = 0`). No error is flagged.

## Timing
- Reset values:
  - State = IFU.
  - `ifu_halt_req`, `host_lock_gnt`, `ifu_rsp_valid`, `host_rsp_valid` = 0.
  - rdata outputs = 0; RAM controls = 0; `itcm_active` = 0.
  - `ifu_cmd_ready = 1` (combinational from reset state).
- Read latency: accept at cycle N → `rsp_valid` at N+1.
- Back-to-back throughput is 1/cycle when `rsp_ready` is held high.
- Lock latency, from `host_lock_req` rising with the IFU idle and ack returned in 1 cycle:
  - DRAIN at N+1; `ifu_halt_req` visible N+1.
  - Ack sampled at N+2 → HOST, `host_lock_gnt = 1` at N+3.
- Reset mid-operation:
  - All outstanding transactions are dropped; no response is issued.
  - `ifu_halt_req` drops immediately (asynchronous).

## Test plan
- IFU reads addr 0x000, 0x001, 0x002 back-to-back with `ifu_rsp_ready = 1` → three responses on consecutive cycles with the RAM contents, `ifu_cmd_ready` held at 1.
- IFU read with `ifu_rsp_ready = 0` for 3 cycles → `ifu_rsp_valid` and rdata stable, `ifu_cmd_ready = 0` until the handshake.
- `host_lock_req` asserted with one IFU fetch outstanding and `ifu_halt_ack` delayed 4 cycles → no grant until the fetch response completes and ack is seen. Then `host_lock_gnt = 1`.
- Host writes 0xDEADBEEF with wmask 0b0011 to 0x010, reads 0x010 (RAM initially 0) → read response 0x0000BEEF. Write response rdata = 0.
- Host drops `host_lock_req` in DRAIN before ack → RELEASE then IFU, `host_lock_gnt` never asserted.
- `rst` pulsed while in HOST with a host response pending → all outputs return to reset values within the same cycle. The FSM is back in IFU with `ifu_cmd_ready = 1`.

Source files
------------

// File: rtl/qpu_itcm_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qpu_itcm_arb : single-port ITCM scheduler between IFU fetch and host load  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module qpu_itcm_arb #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // IFU fetch port
  input  logic            i_ifu_cmd_valid,
  output logic            o_ifu_cmd_ready,
  input  logic [AW-1:0]   i_ifu_cmd_addr,
  output logic            o_ifu_rsp_valid,
  input  logic            i_ifu_rsp_ready,
  output logic [DW-1:0]   o_ifu_rsp_rdata,
  output logic            o_ifu_halt_req,
  input  logic            i_ifu_halt_ack,
  // Host program-load port
  input  logic            i_host_lock_req,
  output logic            o_host_lock_gnt,
  input  logic            i_host_cmd_valid,
  output logic            o_host_cmd_ready,
  input  logic            i_host_cmd_read,
  input  logic [AW-1:0]   i_host_cmd_addr,
  input  logic [DW-1:0]   i_host_cmd_wdata,
  input  logic [DW/8-1:0] i_host_cmd_wmask,
  output logic            o_host_rsp_valid,
  input  logic            i_host_rsp_ready,
  output logic [DW-1:0]   o_host_rsp_rdata,
  // RAM macro
  output logic            o_ram_cs,
  output logic            o_ram_we,
  output logic [AW-1:0]   o_ram_addr,
  output logic [DW/8-1:0] o_ram_wem,
  output logic [DW-1:0]   o_ram_din,
  input  logic [DW-1:0]   i_ram_dout,
  output logic            o_itcm_active
);

  localparam int c_mw = DW / 8;

  typedef enum logic [1:0] {
    S_IFU     = 2'd0,
    S_DRAIN   = 2'd1,
    S_HOST    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_ifu_out;
  logic r_host_out;
  logic r_host_rd;
  logic r_halt_req;
  logic r_lock_gnt;

  logic w_ifu_cmd_ready;
  logic w_host_cmd_ready;
  logic w_ifu_acc;
  logic w_host_acc;
  logic w_host_wr;
  logic w_ram_cs;

  always_comb begin
    w_state_nxt      = r_state;
    w_ifu_cmd_ready  = 1'b0;
    w_host_cmd_ready = 1'b0;
    case (r_state)
      S_IFU: begin
        w_ifu_cmd_ready = ~r_ifu_out | i_ifu_rsp_ready;
        if (i_host_lock_req) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!i_host_lock_req)                  w_state_nxt = S_RELEASE;
        else if (!r_ifu_out && i_ifu_halt_ack) w_state_nxt = S_HOST;
      end
      S_HOST: begin
        w_host_cmd_ready = ~r_host_out | i_host_rsp_ready;
        // A command accepted as the lock falls keeps ownership until it completes.
        if (!i_host_lock_req && !r_host_out && !(i_host_cmd_valid && w_host_cmd_ready))
          w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!i_ifu_halt_ack) w_state_nxt = S_IFU;
      end
      default: w_state_nxt = S_IFU;
    endcase
  end

  assign w_ifu_acc  = i_ifu_cmd_valid  & w_ifu_cmd_ready;
  assign w_host_acc = i_host_cmd_valid & w_host_cmd_ready;
  assign w_host_wr  = w_host_acc & ~i_host_cmd_read;
  assign w_ram_cs   = w_ifu_acc | w_host_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IFU;
      r_halt_req <= 1'b0;
      r_lock_gnt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_halt_req <= (w_state_nxt == S_DRAIN) || (w_state_nxt == S_HOST);
      r_lock_gnt <= (w_state_nxt == S_HOST);
    end
  end

  // Response valid is the outstanding flag itself: set on accept, cleared on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifu_out  <= 1'b0;
      r_host_out <= 1'b0;
      r_host_rd  <= 1'b0;
    end else begin
      if (w_ifu_acc)            r_ifu_out <= 1'b1;
      else if (i_ifu_rsp_ready) r_ifu_out <= 1'b0;

      if (w_host_acc) begin
        r_host_out <= 1'b1;
        r_host_rd  <= i_host_cmd_read;
      end else if (i_host_rsp_ready) begin
        r_host_out <= 1'b0;
      end
    end
  end

  assign o_ram_cs   = w_ram_cs;
  assign o_ram_we   = w_host_wr;
  assign o_ram_addr = w_host_acc ? i_host_cmd_addr : (w_ifu_acc ? i_ifu_cmd_addr : '0);
  assign o_ram_wem  = w_host_wr ? i_host_cmd_wmask : (w_ram_cs ? {c_mw{1'b1}} : {c_mw{1'b0}});
  assign o_ram_din  = w_host_wr ? i_host_cmd_wdata : '0;

  // RAM output holds until the next select, and only the owner can issue one.
  assign o_ifu_rsp_valid  = r_ifu_out;
  assign o_ifu_rsp_rdata  = r_ifu_out ? i_ram_dout : '0;
  assign o_host_rsp_valid = r_host_out;
  assign o_host_rsp_rdata = (r_host_out && r_host_rd) ? i_ram_dout : '0;

  assign o_ifu_cmd_ready  = w_ifu_cmd_ready;
  assign o_host_cmd_ready = w_host_cmd_ready;
  assign o_ifu_halt_req   = r_halt_req;
  assign o_host_lock_gnt  = r_lock_gnt;
  assign o_itcm_active    = (r_state != S_IFU) | r_ifu_out | r_host_out | w_ram_cs;

endmodule
`default_nettype wire

// File: tb/tb_qpu_itcm_arb.sv
`default_nettype none
// Directed bench for qpu_itcm_arb with a behavioural byte-masked RAM model.
module tb_qpu_itcm_arb;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_cmd_valid, ifu_cmd_ready;
  logic [AW-1:0] ifu_cmd_addr;
  logic          ifu_rsp_valid, ifu_rsp_ready;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          ifu_halt_req, ifu_halt_ack;
  logic          host_lock_req, host_lock_gnt;
  logic          host_cmd_valid, host_cmd_ready, host_cmd_read;
  logic [AW-1:0] host_cmd_addr;
  logic [DW-1:0] host_cmd_wdata;
  logic [3:0]    host_cmd_wmask;
  logic          host_rsp_valid, host_rsp_ready;
  logic [DW-1:0] host_rsp_rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          itcm_active;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [4096];

  always #5 clk = ~clk;

  qpu_itcm_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_ifu_cmd_valid(ifu_cmd_valid), .o_ifu_cmd_ready(ifu_cmd_ready),
    .i_ifu_cmd_addr(ifu_cmd_addr),
    .o_ifu_rsp_valid(ifu_rsp_valid), .i_ifu_rsp_ready(ifu_rsp_ready),
    .o_ifu_rsp_rdata(ifu_rsp_rdata),
    .o_ifu_halt_req(ifu_halt_req), .i_ifu_halt_ack(ifu_halt_ack),
    .i_host_lock_req(host_lock_req), .o_host_lock_gnt(host_lock_gnt),
    .i_host_cmd_valid(host_cmd_valid), .o_host_cmd_ready(host_cmd_ready),
    .i_host_cmd_read(host_cmd_read), .i_host_cmd_addr(host_cmd_addr),
    .i_host_cmd_wdata(host_cmd_wdata), .i_host_cmd_wmask(host_cmd_wmask),
    .o_host_rsp_valid(host_rsp_valid), .i_host_rsp_ready(host_rsp_ready),
    .o_host_rsp_rdata(host_rsp_rdata),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wem(ram_wem), .o_ram_din(ram_din), .i_ram_dout(ram_dout),
    .o_itcm_active(itcm_active)
  );

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    logic          cv;
    logic [AW-1:0] ca;
    logic          rr;
    logic          e_cr;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_cs;
    logic          e_act;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = (i < 16) ? (32'hC0DE_0000 | i) : 32'h0;

    //        cv   ca      rr    cr    rv    rdata          cs    act
    vecs[0]  = '{1'b1, 12'h000, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vecs[1]  = '{1'b1, 12'h001, 1'b1, 1'b1, 1'b1, 32'hC0DE_0000, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 12'h002, 1'b1, 1'b1, 1'b1, 32'hC0DE_0001, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 32'hC0DE_0002, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[5]  = '{1'b1, 12'h003, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vecs[6]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 32'hC0DE_0003, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 12'h004, 1'b0, 1'b0, 1'b1, 32'hC0DE_0003, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 32'hC0DE_0003, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 32'hC0DE_0003, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};

    rst = 1'b1;
    ifu_cmd_valid = 0; ifu_cmd_addr = '0; ifu_rsp_ready = 0; ifu_halt_ack = 0;
    host_lock_req = 0; host_cmd_valid = 0; host_cmd_read = 0; host_cmd_addr = '0;
    host_cmd_wdata = '0; host_cmd_wmask = '0; host_rsp_ready = 0;

    repeat (2) @(posedge clk);
    smp();
    chk("rst_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd1);
    chk("rst_halt_req",      32'(ifu_halt_req), 32'd0);
    chk("rst_lock_gnt",      32'(host_lock_gnt), 32'd0);
    chk("rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    chk("rst_host_rsp_valid",32'(host_rsp_valid), 32'd0);
    chk("rst_ram_cs",        32'(ram_cs), 32'd0);
    chk("rst_active",        32'(itcm_active), 32'd0);
    cyc();
    rst = 1'b0;

    // IFU back-to-back reads, then a stalled response
    for (int i = 0; i < 11; i++) begin
      cyc();
      ifu_cmd_valid = vecs[i].cv;
      ifu_cmd_addr  = vecs[i].ca;
      ifu_rsp_ready = vecs[i].rr;
      smp();
      chk($sformatf("vec%0d_cmd_ready", i), 32'(ifu_cmd_ready), 32'(vecs[i].e_cr));
      chk($sformatf("vec%0d_rsp_valid", i), 32'(ifu_rsp_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d_rdata", i),     ifu_rsp_rdata,      vecs[i].e_rd);
      chk($sformatf("vec%0d_ram_cs", i),    32'(ram_cs),        32'(vecs[i].e_cs));
      chk($sformatf("vec%0d_active", i),    32'(itcm_active),   32'(vecs[i].e_act));
      if (vecs[i].e_cs) chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].ca));
    end

    // Lock with a fetch outstanding and a delayed halt ack
    cyc();
    ifu_cmd_valid = 1; ifu_cmd_addr = 12'h005; ifu_rsp_ready = 0; host_lock_req = 1;
    smp();
    chk("lk0_ram_cs", 32'(ram_cs), 32'd1);
    cyc();
    ifu_cmd_valid = 0;
    smp();
    chk("lk1_halt_req",  32'(ifu_halt_req), 32'd1);
    chk("lk1_cmd_ready", 32'(ifu_cmd_ready), 32'd0);
    chk("lk1_gnt",       32'(host_lock_gnt), 32'd0);
    chk("lk1_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
    chk("lk1_rdata",     ifu_rsp_rdata, 32'hC0DE_0005);
    cyc();
    ifu_rsp_ready = 1;
    smp();
    chk("lk2_gnt", 32'(host_lock_gnt), 32'd0);
    cyc();
    ifu_rsp_ready = 0;
    smp();
    chk("lk3_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    chk("lk3_gnt",       32'(host_lock_gnt), 32'd0);
    cyc();
    ifu_halt_ack = 1;
    smp();
    chk("lk4_gnt", 32'(host_lock_gnt), 32'd0);
    cyc();
    smp();
    chk("lk5_gnt",            32'(host_lock_gnt), 32'd1);
    chk("lk5_halt_req",       32'(ifu_halt_req), 32'd1);
    chk("lk5_host_cmd_ready", 32'(host_cmd_ready), 32'd1);
    chk("lk5_ifu_cmd_ready",  32'(ifu_cmd_ready), 32'd0);

    // Host masked write then read-back
    cyc();
    host_cmd_valid = 1; host_cmd_read = 0; host_cmd_addr = 12'h010;
    host_cmd_wdata = 32'hDEAD_BEEF; host_cmd_wmask = 4'b0011; host_rsp_ready = 1;
    smp();
    chk("hw_ram_cs",   32'(ram_cs), 32'd1);
    chk("hw_ram_we",   32'(ram_we), 32'd1);
    chk("hw_ram_wem",  32'(ram_wem), 32'h3);
    chk("hw_ram_addr", 32'(ram_addr), 32'h10);
    chk("hw_ram_din",  ram_din, 32'hDEAD_BEEF);
    cyc();
    host_cmd_read = 1;
    smp();
    chk("hr_wr_rsp_valid", 32'(host_rsp_valid), 32'd1);
    chk("hr_wr_rsp_rdata", host_rsp_rdata, 32'h0);
    chk("hr_ram_we",       32'(ram_we), 32'd0);
    chk("hr_ram_wem",      32'(ram_wem), 32'hF);
    cyc();
    host_cmd_valid = 0;
    smp();
    chk("hr_rsp_valid", 32'(host_rsp_valid), 32'd1);
    chk("hr_rsp_rdata", host_rsp_rdata, 32'h0000_BEEF);
    cyc();
    host_lock_req = 0;
    smp();
    chk("rel0_rsp_valid", 32'(host_rsp_valid), 32'd0);
    chk("rel0_gnt",       32'(host_lock_gnt), 32'd1);
    cyc();
    smp();
    chk("rel1_gnt",            32'(host_lock_gnt), 32'd0);
    chk("rel1_halt_req",       32'(ifu_halt_req), 32'd0);
    chk("rel1_host_cmd_ready", 32'(host_cmd_ready), 32'd0);
    chk("rel1_ifu_cmd_ready",  32'(ifu_cmd_ready), 32'd0);
    chk("rel1_active",         32'(itcm_active), 32'd1);
    cyc();
    ifu_halt_ack = 0;
    smp();
    chk("rel2_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd0);
    cyc();
    smp();
    chk("rel3_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd1);
    chk("rel3_active",        32'(itcm_active), 32'd0);

    // Lock request withdrawn while draining
    cyc();
    host_lock_req = 1;
    smp();
    chk("dr0_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd1);
    cyc();
    host_lock_req = 0;
    smp();
    chk("dr1_halt_req",      32'(ifu_halt_req), 32'd1);
    chk("dr1_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd0);
    chk("dr1_gnt",           32'(host_lock_gnt), 32'd0);
    cyc();
    smp();
    chk("dr2_halt_req",      32'(ifu_halt_req), 32'd0);
    chk("dr2_gnt",           32'(host_lock_gnt), 32'd0);
    chk("dr2_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd0);
    chk("dr2_active",        32'(itcm_active), 32'd1);
    cyc();
    smp();
    chk("dr3_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd1);
    chk("dr3_gnt",           32'(host_lock_gnt), 32'd0);

    // Reset pulsed in HOST with a host response pending
    cyc();
    host_lock_req = 1; ifu_halt_ack = 1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      smp();
      if (host_lock_gnt) break;
    end
    chk("rs_gnt_reached", 32'(host_lock_gnt), 32'd1);
    cyc();
    host_cmd_valid = 1; host_cmd_read = 1; host_cmd_addr = 12'h010; host_rsp_ready = 0;
    smp();
    chk("rs_ram_cs", 32'(ram_cs), 32'd1);
    cyc();
    smp();
    chk("rs_rsp_valid",  32'(host_rsp_valid), 32'd1);
    chk("rs_rsp_rdata",  host_rsp_rdata, 32'h0000_BEEF);
    chk("rs_cmd_ready",  32'(host_cmd_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rs_halt_req",       32'(ifu_halt_req), 32'd0);
    chk("rs_gnt",            32'(host_lock_gnt), 32'd0);
    chk("rs_host_rsp_valid", 32'(host_rsp_valid), 32'd0);
    chk("rs_host_rdata",     host_rsp_rdata, 32'h0);
    chk("rs_ifu_cmd_ready",  32'(ifu_cmd_ready), 32'd1);
    chk("rs_host_cmd_ready", 32'(host_cmd_ready), 32'd0);
    chk("rs_ram_cs_off",     32'(ram_cs), 32'd0);
    chk("rs_active",         32'(itcm_active), 32'd0);
    host_cmd_valid = 0; host_lock_req = 0; ifu_halt_ack = 0;
    cyc();
    rst = 1'b0;
    cyc();
    smp();
    chk("post_rs_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd1);
    chk("post_rs_rsp_valid",     32'(host_rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
